// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with occupancy count, threshold and sticky error flags
// Optional build macro: SYNC_FIFO_FWFT_EN (first-word-fall-through read port).
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         w_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         r_en,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  w_rd_acc;
  logic                  w_wr_acc;

  assign empty        = (r_count == '0);
  assign full         = (r_count == FULL_C);
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

  // A read frees a slot in the same edge, so a full FIFO still accepts a paired write.
  assign w_rd_acc = r_en & ~empty;
  assign w_wr_acc = w_en & (~full | w_rd_acc);

  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_wr_acc) begin
      r_mem[r_wptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
      if (w_rd_acc) r_rptr <= r_rptr + AW'(1);
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + CW'(1);
      else if (w_rd_acc && !w_wr_acc) r_count <= r_count - CW'(1);
      if (w_en && !w_wr_acc) r_ovf <= 1'b1;
      if (r_en && !w_rd_acc) r_udf <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = empty ? '0 : r_mem[r_rptr];
`else
  logic [DATA_WIDTH-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_dout <= '0;
    end else if (w_rd_acc) begin
      r_dout <= r_mem[r_rptr];
    end
  end

  assign data_out = r_dout;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - queue-model self-checking bench for sync_fifo_flags
module tb_sync_fifo_flags;
  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          w_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          r_en = 1'b0;
  logic [DW-1:0] data_out;
  logic          full, empty, almost_full, almost_empty;
  logic [3:0]    count;
  logic          overflow, underflow;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;
  logic [DW-1:0] m_dout = '0;

  sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: occupancy is the queue length, reads pop the head, writes push the tail.
  always @(posedge clk) begin
    bit rd, wr;
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_dout = '0;
    end else if (flush) begin
      q.delete();
      m_dout = '0;
    end else begin
      rd = r_en && (q.size() > 0);
      wr = w_en && ((q.size() < DEPTH) || rd);
      if (w_en && !wr) m_ovf = 1'b1;
      if (r_en && !rd) m_udf = 1'b1;
      if (rd) m_dout = q.pop_front();
      if (wr) q.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = q.size();
      chk("count", 32'(count), 32'(n));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(n >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
      chk("data_out", 32'(data_out), (n == 0) ? 32'h0 : 32'(q[0]));
`else
      chk("data_out", 32'(data_out), 32'(m_dout));
`endif
    end
  end

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic f = 1'b0, input logic rn = 1'b1);
    w_en = w; data_in = d; r_en = r; flush = f; rst_n = rn;
    @(negedge clk);
  endtask

  task automatic read_chk(input logic [DW-1:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk("head_word", 32'(data_out), 32'(exp));
    step(1'b0, 8'h00, 1'b1);
`else
    step(1'b0, 8'h00, 1'b1);
    chk("read_word", 32'(data_out), 32'(exp));
`endif
  endtask

  initial begin
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);

    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0);
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_ae", 32'(almost_empty), 32'(i + 1 <= 2));
      chk("fill_af", 32'(almost_full), 32'(i + 1 >= 6));
      chk("fill_full", 32'(full), 32'(i + 1 == 8));
    end
    for (int i = 0; i < 8; i++) read_chk(8'(8'h10 + i));
    chk("drained_empty", 32'(empty), 32'd1);

    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    step(1'b1, 8'hAA, 1'b1);
    chk("full_wr_rd_count", 32'(count), 32'd8);
    chk("full_wr_rd_ovf", 32'(overflow), 32'd0);
    step(1'b1, 8'h55, 1'b0);
    chk("full_wr_count", 32'(count), 32'd8);
    chk("full_wr_ovf", 32'(overflow), 32'd1);
    for (int i = 1; i < 8; i++) read_chk(8'(8'h20 + i));
    read_chk(8'hAA);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    step(1'b1, 8'h33, 1'b1);
    chk("empty_wr_rd_udf", 32'(underflow), 32'd1);
    chk("empty_wr_rd_count", 32'(count), 32'd1);
    read_chk(8'h33);

    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h50 + i), 1'b1);
    chk("wrap_count", 32'(count), 32'd3);
`ifdef SYNC_FIFO_FWFT_EN
    chk("wrap_head", 32'(data_out), 32'h59);
`endif
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_ovf", 32'(overflow), 32'd1);
    chk("flush_udf", 32'(underflow), 32'd1);
    chk("flush_dout", 32'(data_out), 32'd0);

    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      int wp, rp;
      logic f, rn;
      wp = ((i / 150) % 2 == 0) ? 75 : 30;
      rp = 105 - wp;
      f  = ($urandom_range(0, 63) == 0);
      rn = ($urandom_range(0, 399) != 0);
      step(($urandom_range(0, 99) < wp), 8'($urandom), ($urandom_range(0, 99) < rp), f, rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
